// File: rtl/chip8_pkg.sv
// Shared constants and state encoding for the CHIP-8 sprite draw sequencer.
package chip8_pkg;

  localparam int SCREEN_W        = 64;
  localparam int SCREEN_H        = 32;
  localparam int ADDR_W          = 12;
  localparam int SPRITE_ROWS_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_DRAW,
    ST_DONE
  } draw_state_t;

endpackage

// File: rtl/chip8_draw_seq.sv
// DXYN sprite draw sequencer: fetches N sprite bytes from memory and strobes
// them row by row into the display XOR datapath, OR-ing collisions into VF.
module chip8_draw_seq #(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [11:0] i_addr,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic        vf,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic        draw,
  output logic [5:0]  x,
  output logic [4:0]  y,
  output logic [3:0]  row_index,
  output logic [7:0]  sprite_data,
  input  logic        collision
);
  import chip8_pkg::*;

  draw_state_t       state_q, state_d;
  logic [5:0]        x_q;
  logic [4:0]        y_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        n_q;
  logic [3:0]        row_q;
  logic [7:0]        sprite_q;
  logic              vf_q;
  logic              last_row;

  // Rows are counted 0..n-1; only meaningful in DRAW where n >= 1.
  assign last_row = (row_q == (n_q - 4'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (n == 4'd0) ? ST_DONE : ST_ADDR;
      ST_ADDR: if (mem_gnt) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_DRAW;
      ST_DRAW: state_d = last_row ? ST_DONE : ST_ADDR;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on start, capture sprite byte, step rows, fold collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      base_q   <= '0;
      n_q      <= '0;
      row_q    <= '0;
      sprite_q <= '0;
      vf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          // Only the origin is reduced here; per-pixel wrap/clip is the display's job.
          x_q    <= 6'(vx % 8'(SCREEN_W));
          y_q    <= 5'(vy % 8'(SCREEN_H));
          base_q <= i_addr;
          n_q    <= n;
          row_q  <= '0;
          vf_q   <= 1'b0;
        end
        ST_WAIT: sprite_q <= mem_rdata;
        ST_DRAW: begin
          vf_q <= vf_q | collision;
          if (!last_row) row_q <= row_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // All outputs come from registered state; the address adder wraps at 4 KiB.
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign mem_req     = (state_q == ST_ADDR);
  assign draw        = (state_q == ST_DRAW);
  assign mem_addr    = base_q + {8'd0, row_q};
  assign vf          = vf_q;
  assign x           = x_q;
  assign y           = y_q;
  assign row_index   = row_q;
  assign sprite_data = sprite_q;

endmodule

// File: doc/chip8_draw_seq.md
# chip8_draw_seq

Sequencer for the CHIP-8 DXYN sprite draw. On a start request from the CPU it reads N sprite bytes from shared memory starting at I, presents them row by row to the display XOR datapath with one-cycle draw strobes, and accumulates the collision flag into VF. It owns the draw/x/y/row_index/sprite_data interface into chip8_display and requests the memory port through a req/gnt handshake while the CPU is stalled on busy.

## Interface
- SCREEN_W, 64: display width in pixels; x wraps modulo this value.
- SCREEN_H, 32: display height in pixels; y wraps modulo this value.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle draw request; honoured only in IDLE.
- vx  in  8  VX register value; sampled on start.
- vy  in  8  VY register value; sampled on start.
- i_addr  in  12  I register; sampled on start.
- n  in  4  sprite height in rows; sampled on start.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  one-cycle pulse when the sequence completes.
- vf  out  1  collision result; valid when done is high; held until the next accepted start.
- mem_req  out  1  memory port request.
- mem_addr  out  12  read address, (i_addr + row) mod 4096.
- mem_gnt  in  1  memory port grant, same-cycle response to mem_req.
- mem_rdata  in  8  read data, valid the cycle after a granted request.
- draw  out  1  one-cycle row draw strobe to chip8_display.
- x  out  6  vx mod SCREEN_W, held for the whole sequence.
- y  out  5  vy mod SCREEN_H, held for the whole sequence.
- row_index  out  4  current row, 0..n-1.
- sprite_data  out  8  current sprite byte.
- collision  in  1  display collision for the current strobe, valid the same cycle as draw.

## Operation
- States: IDLE, ADDR, WAIT, DRAW, DONE.
- IDLE: on start, latch x, y, base address, n. Clear row to 0 and vf to 0. Go to ADDR, or to DONE if n == 0. start is ignored in every other state.
- ADDR: mem_req=1, mem_addr=base+row (12-bit wrap, 0xFFF+1 → 0x000). If mem_gnt=1, go to WAIT; otherwise stay, holding req and addr.
- WAIT: mem_req=0. Capture mem_rdata into the sprite register. Go to DRAW.
- DRAW: draw=1, row_index=row, sprite_data=sprite register. vf <= vf | collision. If row == n-1, go to DONE; else row+1 and go to ADDR.
- DONE: done=1, busy=1. Go to IDLE.
- Clipping and per-pixel wrap are the display's job. The sequencer only reduces the start coordinates modulo the screen size.
- Reset at any point: state IDLE, no further draw or mem_req; a partially drawn sprite stays partially drawn.
- Reset values: busy=0, done=0, vf=0, mem_req=0, mem_addr=0, draw=0, x=0, y=0, row_index=0, sprite_data=0.

## Timing
- start sampled at edge k. ADDR occupies cycle k+1.
- With mem_gnt tied high, each row takes 3 cycles (ADDR, WAIT, DRAW). Row r strobes draw in cycle k+3r+3.
- done is asserted in cycle k+3n+1; for n=0, done is asserted in cycle k+1. IDLE is re-entered the following cycle.
- Each cycle mem_gnt is low in ADDR adds one cycle to that row.
- draw, done and mem_req are never high in the same cycle. draw is high exactly n times per sequence.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs. collision is sampled only at the edge ending DRAW.

## Structure
- chip8_pkg holds:
  - the state enum (draw_state_t);
  - SCREEN_W, SCREEN_H, ADDR_W=12, SPRITE_ROWS_MAX=15.
- No sub-module: one FSM plus a row counter, address adder and sprite register.
- Memory arbitration between CPU and sequencer is outside this block.

## Test plan
- Basic draw: vx=10, vy=5, i_addr=0x050, n=5 (font "0"), gnt=1, collision=0 → draw pulses at k+3, +6, +9, +12, +15. mem_addr sequence 0x050..0x054. sprite_data sequence F0,90,90,90,F0. done at k+16, vf=0.
- Collision: same sprite with collision=1 on row 2 only → vf=1 at done and held until the next start; the next start clears vf to 0.
- Wrap: vx=70, vy=40, i_addr=0xFFE, n=3 → x=6, y=8, mem_addr sequence 0xFFE, 0xFFF, 0x000.
- Grant stall: gnt=0 for 4 cycles in row 0's ADDR → mem_req and mem_addr held steady. First draw at k+7, done at k+3n+5.
- Edge cases:
  - n=0 → no mem_req, no draw, done at k+1, vf=0.
  - start pulsed while busy → ignored; the in-flight sequence is unaffected.
- Reset in WAIT of row 1 → next cycle: all outputs at reset values, no draw issued, and a subsequent start behaves as in the basic draw scenario.
